// File: rtl/memory_arbiter.sv
// Two-requester RAM arbiter: data accesses beat instruction fetches, with a per-access timeout.
// Optional hit counters (dcount/icount) are built when MEMORY_ARBITER_STATS_EN is defined.
module memory_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        err
`ifdef MEMORY_ARBITER_STATS_EN
  ,
  output logic [15:0] dcount,
  output logic [15:0] icount
`endif
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DACC, IACC} state_t;

  state_t        state;
  logic [CW-1:0] waitCnt;
  logic [31:0]   dloadQ;
  logic [31:0]   iloadQ;

  // Hits are combinational on ramready so the requester sees completion in the RAM's cycle.
  assign dhit  = (state == DACC) && ramready && !RST;
  assign ihit  = (state == IACC) && ramready && !RST;
  assign dload = (dhit && ramREN) ? ramload : dloadQ;
  assign iload = ihit ? ramload : iloadQ;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      waitCnt  <= '0;
      err      <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      dloadQ   <= '0;
      iloadQ   <= '0;
    end else begin
      case (state)
        IDLE: begin
          waitCnt <= '0;
          if (dREN || dWEN) begin
            state    <= DACC;
            ramaddr  <= daddr;
            ramstore <= dstore;
            ramWEN   <= dWEN;
            ramREN   <= !dWEN;
          end else if (iREN) begin
            state   <= IACC;
            ramaddr <= iaddr;
            ramREN  <= 1'b1;
            ramWEN  <= 1'b0;
          end
        end
        DACC, IACC: begin
          if (ramready) begin
            state  <= IDLE;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            if (dhit && ramREN) dloadQ <= ramload;
            if (ihit)           iloadQ <= ramload;
          end else begin
            waitCnt <= waitCnt + 1'b1;
            // The edge that brings the count to TIMEOUT abandons the access.
            if (waitCnt == LAST_WAIT) begin
              state  <= IDLE;
              ramREN <= 1'b0;
              ramWEN <= 1'b0;
              err    <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEMORY_ARBITER_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      dcount <= '0;
      icount <= '0;
    end else begin
      if (dhit && dcount != 16'hFFFF) dcount <= dcount + 16'd1;
      if (ihit && icount != 16'hFFFF) icount <= icount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: expected hits go into a queue, a negedge monitor pops and checks them.
module tb_memory_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0, ramready = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic        ihit, dhit, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef MEMORY_ARBITER_STATS_EN
  logic [15:0] dcount, icount;
`endif

  typedef struct {
    bit          isData;
    bit          chkLoad;
    logic [31:0] load;
  } exp_t;

  exp_t expQ[$];
  int   tests = 0;
  int   fails = 0;

  memory_arbiter #(.TIMEOUT(15)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .err(err)
`ifdef MEMORY_ARBITER_STATS_EN
    , .dcount(dcount), .icount(icount)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic pushExp(input bit isData, input bit chkLoad, input logic [31:0] load);
    exp_t e;
    e.isData = isData;
    e.chkLoad = chkLoad;
    e.load = load;
    expQ.push_back(e);
  endtask

  // Monitor: every hit must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (ihit || dhit) begin
      exp_t e;
      tests++;
      if (ihit && dhit) begin
        fails++;
        $display("FAIL hit_exclusive: ihit=%b dhit=%b, expected only one", ihit, dhit);
      end else if (expQ.size() == 0) begin
        fails++;
        $display("FAIL unexpected_hit: ihit=%b dhit=%b, expected no hit", ihit, dhit);
      end else begin
        e = expQ.pop_front();
        if (dhit != e.isData) begin
          fails++;
          $display("FAIL hit_kind: dhit=%b, expected dhit=%b", dhit, e.isData);
        end else if (e.chkLoad && (dhit ? dload : iload) !== e.load) begin
          fails++;
          $display("FAIL hit_load: got %h, expected %h", dhit ? dload : iload, e.load);
        end
      end
    end
  end

  task automatic dataRead(input logic [31:0] addr, input logic [31:0] val);
    tick(); dREN = 1'b1; daddr = addr; pushExp(1'b1, 1'b1, val);
    tick(); dREN = 1'b0; ramready = 1'b1; ramload = val;
    sample(); chk("dataRead_dload", dload, val);
    tick(); ramready = 1'b0; ramload = '0;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] val);
    tick(); iREN = 1'b1; iaddr = addr; pushExp(1'b0, 1'b1, val);
    tick(); iREN = 1'b0; ramready = 1'b1; ramload = val;
    sample(); chk("fetch_iload", iload, val);
    tick(); ramready = 1'b0; ramload = '0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    sample();
    chk("rst_ramREN", {31'b0, ramREN}, 32'd0);
    chk("rst_ramWEN", {31'b0, ramWEN}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_dload", dload, 32'd0);
    chk("rst_iload", iload, 32'd0);
`ifdef MEMORY_ARBITER_STATS_EN
    chk("rst_dcount", {16'd0, dcount}, 32'd0);
`endif
    tick(); RST = 1'b0;

    // Single read, ready on the second RAM cycle; ramready in IDLE is ignored
    ramready = 1'b1;
    sample(); chk("idle_ready_dhit", {31'b0, dhit}, 32'd0);
    tick(); ramready = 1'b0; dREN = 1'b1; daddr = 32'h100; pushExp(1'b1, 1'b1, 32'hDEADBEEF);
    sample(); chk("rd_latency_ramREN", {31'b0, ramREN}, 32'd0);
    tick(); dREN = 1'b0;
    sample(); chk("rd_c1_ramREN", {31'b0, ramREN}, 32'd1);
    chk("rd_c1_ramWEN", {31'b0, ramWEN}, 32'd0);
    chk("rd_c1_ramaddr", ramaddr, 32'h100);
    tick(); ramready = 1'b1; ramload = 32'hDEADBEEF;
    sample(); chk("rd_c2_ramREN", {31'b0, ramREN}, 32'd1);
    chk("rd_c2_ramaddr", ramaddr, 32'h100);
    chk("rd_dload", dload, 32'hDEADBEEF);
    tick(); ramready = 1'b0; ramload = '0;
    sample(); chk("rd_done_ramREN", {31'b0, ramREN}, 32'd0);
    chk("rd_hold_dload", dload, 32'hDEADBEEF);
    chk("rd_hold_ramaddr", ramaddr, 32'h100);

    // Contention: write (both dREN and dWEN) beats fetch
    tick(); iREN = 1'b1; iaddr = 32'h200; dWEN = 1'b1; dREN = 1'b1;
    daddr = 32'h300; dstore = 32'h12345678;
    pushExp(1'b1, 1'b0, 32'h0); pushExp(1'b0, 1'b1, 32'hCAFEF00D);
    tick(); dWEN = 1'b0; dREN = 1'b0;
    sample(); chk("wr_ramWEN", {31'b0, ramWEN}, 32'd1);
    chk("wr_ramREN", {31'b0, ramREN}, 32'd0);
    chk("wr_ramstore", ramstore, 32'h12345678);
    chk("wr_ramaddr", ramaddr, 32'h300);
    tick(); ramready = 1'b1;
    sample();
    tick(); ramready = 1'b0;
    sample(); chk("b2b_idle_ramREN", {31'b0, ramREN}, 32'd0);
    chk("b2b_idle_ramWEN", {31'b0, ramWEN}, 32'd0);
    chk("wr_no_dload_update", dload, 32'hDEADBEEF);
    tick(); iREN = 1'b0;
    sample(); chk("if_ramREN", {31'b0, ramREN}, 32'd1);
    chk("if_ramaddr", ramaddr, 32'h200);
    chk("if_ramstore_hold", ramstore, 32'h12345678);
    tick(); ramready = 1'b1; ramload = 32'hCAFEF00D;
    sample(); chk("if_iload", iload, 32'hCAFEF00D);
    tick(); ramready = 1'b0; ramload = '0;

    fetch(32'h240, 32'h0000_1111);

    // Timeout: 15 waiting cycles, then abort with err set
    tick(); dREN = 1'b1; daddr = 32'h400;
    tick(); dREN = 1'b0;
    for (int i = 0; i < 15; i++) begin
      sample(); chk($sformatf("to_wait%0d_ramREN", i), {31'b0, ramREN}, 32'd1);
      tick();
    end
    sample(); chk("to_abort_ramREN", {31'b0, ramREN}, 32'd0);
    chk("to_err", {31'b0, err}, 32'd1);

    dataRead(32'h500, 32'hA5A5_5A5A);
    sample(); chk("err_sticky", {31'b0, err}, 32'd1);
`ifdef MEMORY_ARBITER_STATS_EN
    chk("stats_dcount", {16'd0, dcount}, 32'd3);
    chk("stats_icount", {16'd0, icount}, 32'd2);
`endif

    // Reset mid-fetch: no hit, err cleared, immediate re-grant
    tick(); iREN = 1'b1; iaddr = 32'h600;
    tick(); iREN = 1'b0;
    sample(); chk("mid_ramREN", {31'b0, ramREN}, 32'd1);
    tick(); RST = 1'b1; ramready = 1'b1; ramload = 32'hFFFF_0000;
    sample(); chk("mid_rst_ihit", {31'b0, ihit}, 32'd0);
    tick(); RST = 1'b0; ramready = 1'b0; ramload = '0;
    iREN = 1'b1; iaddr = 32'h700; pushExp(1'b0, 1'b1, 32'h0BADC0DE);
    sample(); chk("post_rst_ramREN", {31'b0, ramREN}, 32'd0);
    chk("post_rst_err", {31'b0, err}, 32'd0);
    chk("post_rst_ihit", {31'b0, ihit}, 32'd0);
    tick(); iREN = 1'b0;
    sample(); chk("regrant_ramREN", {31'b0, ramREN}, 32'd1);
    chk("regrant_ramaddr", ramaddr, 32'h700);
    tick(); ramready = 1'b1; ramload = 32'h0BADC0DE;
    sample();
    tick(); ramready = 1'b0; ramload = '0;
    sample(); chk("regrant_iload_hold", iload, 32'h0BADC0DE);
`ifdef MEMORY_ARBITER_STATS_EN
    chk("stats_after_rst_icount", {16'd0, icount}, 32'd1);
    chk("stats_after_rst_dcount", {16'd0, dcount}, 32'd0);
`endif

    tick(); tick();
    sample();
    chk("pending_hits", expQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15, is the maximum number of cycles an access waits for ramready before it is aborted.
REQ-002 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 RST  input  1  reset; synchronous, active-high.
REQ-004 iREN  input  1  instruction fetch request; iaddr  input  32  fetch address.
REQ-005 dREN, dWEN  input  1 each  data read/write requests (from request unit); daddr  input  32; dstore  input  32  write data.
REQ-006 ihit, dhit  output  1 each  one-cycle completion pulses; iload, dload  output  32  returned read data.
REQ-007 ramREN, ramWEN  output  1 each; ramaddr  output  32; ramstore  output  32  RAM port drive.
REQ-008 ramload  input  32  RAM read data; ramready  input  1  RAM completes the current access this cycle.
REQ-009 err  output  1  sticky timeout flag.

Function
REQ-010 FSM states: IDLE, DACC, IACC; state register resets to IDLE.
REQ-011 IDLE: dREN|dWEN -> DACC; else iREN -> IACC; else stay IDLE; data has strict priority over instruction.
REQ-012 On the IDLE->DACC/IACC transition, address, store data and the op type are captured into registers; the RAM port is driven from these registers only, never directly from the request inputs.
REQ-013 The RAM request is asserted in the cycle after the request is sampled in IDLE (one-cycle grant latency).
REQ-014 dWEN and dREN both high at grant: access is a write (ramWEN=1, ramREN=0).
REQ-015 ramREN/ramWEN are mutually exclusive and both 0 in IDLE; ramaddr/ramstore hold the last captured value in IDLE.
REQ-016 DACC: when ramready=1, dhit=1 in that same cycle, dload=ramload for reads, FSM -> IDLE.
REQ-017 IACC: when ramready=1, ihit=1 in that same cycle, iload=ramload, FSM -> IDLE.
REQ-018 ihit and dhit are never high in the same cycle; each is high for exactly one cycle per access.
REQ-019 A request withdrawn after grant does not cancel the access; it completes and still pulses its hit.
REQ-020 Back-to-back: after a hit, the arbiter spends one cycle in IDLE before the next grant; a pending data request then wins over a pending fetch.
REQ-021 A wait counter clears on grant and increments each cycle in DACC/IACC without ramready; at count == TIMEOUT the access is aborted, FSM -> IDLE, no hit pulse, err set to 1.
REQ-022 ramready=1 in IDLE is ignored.
REQ-023 dload/iload hold their last returned value until the next hit.

Reset
REQ-024 RST=1 at a clock edge: state=IDLE, wait counter=0, err=0, ihit=dhit=0, ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0.
REQ-025 RST asserted mid-access aborts the access with no hit pulse; the first grant can occur the cycle after RST deasserts.

Configuration
REQ-026 With MEMORY_ARBITER_STATS_EN defined: extra outputs dcount and icount (16-bit each) count completed data and instruction hits, saturate at 16'hFFFF, and reset to 0.
REQ-027 Without MEMORY_ARBITER_STATS_EN: dcount/icount ports and counters do not exist; all other behaviour is identical.

Verification
REQ-028 Single read: dREN=1, daddr=0x100, ramready high on the 2nd RAM cycle with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x100 for 2 cycles, dhit=1 for one cycle, dload=0xDEADBEEF.
REQ-029 Contention: iREN=1 and dWEN=1 in the same cycle, dstore=0x12345678 -> data write granted first (ramWEN=1, ramstore=0x12345678), then after dhit plus one IDLE cycle the fetch is granted and ihit pulses.
REQ-030 Timeout: dREN=1, ramready held 0 -> after 15 waiting cycles the FSM returns to IDLE, dhit never pulses, err=1 until RST.
REQ-031 Reset mid-access: RST=1 during IACC -> next cycle ramREN=0, ihit=0, err=0; a new iREN is granted normally.
REQ-032 Stats (MEMORY_ARBITER_STATS_EN defined): 3 data hits and 2 fetch hits -> dcount=3, icount=2; with the macro undefined the bench compiles without these ports.
